// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward controller for the 5-stage RV32 pipeline.
// Detects load-use hazards by register compare, selects EX operand forwarding,
// holds EX for the multi-cycle mul/div unit, and counts hazard events.
//
// Ports
//   i_clk, i_rst                        clock, synchronous active-high reset
//   i_id_*                              ID-stage valid, register-use flags, source regs
//   i_ex_*                              EX-stage flags, source/destination regs, redirect
//   i_mem_*, i_wb_*                     MEM/WB destination write info
//   o_stall_if, o_stall_id              hold PC and IF/ID
//   o_hold_ex                           hold ID/EX
//   o_bubble_ex, o_bubble_mem           insert NOP into ID/EX, EX/MEM
//   o_flush_if_id                       kill IF/ID
//   o_fwd_a, o_fwd_b                    00 regfile, 01 EX/MEM, 10 MEM/WB
//   o_muldiv_start, o_muldiv_done       one-cycle pulses to the mul/div unit
//   o_muldiv_busy                       mul/div sequencer is BUSY
//   o_stall_cnt, o_flush_cnt, o_muldiv_cnt  wrapping performance counters
module hazard_ctrl #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 33,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic             i_id_uses_rs1,
    input  logic             i_id_uses_rs2,
    input  logic [4:0]       i_id_ra1,
    input  logic [4:0]       i_id_ra2,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_load,
    input  logic             i_ex_reg_write_en,
    input  logic             i_ex_is_muldiv,
    input  logic             i_ex_is_div,
    input  logic [4:0]       i_ex_ra1,
    input  logic [4:0]       i_ex_ra2,
    input  logic [4:0]       i_ex_wa3,
    input  logic             i_ex_redirect,
    input  logic             i_mem_reg_write_en,
    input  logic             i_mem_is_load,
    input  logic [4:0]       i_mem_wa3,
    input  logic             i_wb_reg_write_en,
    input  logic [4:0]       i_wb_wa3,
    output logic             o_stall_if,
    output logic             o_stall_id,
    output logic             o_hold_ex,
    output logic             o_bubble_ex,
    output logic             o_bubble_mem,
    output logic             o_flush_if_id,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_muldiv_start,
    output logic             o_muldiv_done,
    output logic             o_muldiv_busy,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_muldiv_cnt
);

    localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    // Counter only ever holds LAT-2 down to 0.
    localparam int unsigned CW = (MAX_LAT >= 3) ? $clog2(MAX_LAT - 1) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 2);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 2);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_muldiv_cnt;
    logic            w_lu;
    logic            w_held;

    // Operand source select; MEM wins over WB, loads in MEM have no result yet.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] ra,
        input logic       mem_we,
        input logic       mem_ld,
        input logic [4:0] mem_wa,
        input logic       wb_we,
        input logic [4:0] wb_wa
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_we && !mem_ld && (mem_wa != 5'd0) && (mem_wa == ra)) begin
            sel = FWD_MEM;
        end else if (wb_we && (wb_wa != 5'd0) && (wb_wa == ra)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Load in EX whose destination is read by the instruction in ID.
    assign w_lu = i_ex_valid && i_ex_is_load && i_ex_reg_write_en && (i_ex_wa3 != 5'd0)
               && i_id_valid
               && ((i_id_uses_rs1 && (i_id_ra1 == i_ex_wa3))
                || (i_id_uses_rs2 && (i_id_ra2 == i_ex_wa3)));

    // State, sequencer counter and performance counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_muldiv_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_stall_cnt  <= r_stall_cnt + CNT_W'(o_stall_id);
            r_flush_cnt  <= r_flush_cnt + CNT_W'(o_flush_if_id);
            r_muldiv_cnt <= r_muldiv_cnt + CNT_W'(o_muldiv_start);
        end
    end

    // Next state and all pipeline controls; reset forces every control low.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_held         = 1'b0;
        o_stall_if     = 1'b0;
        o_stall_id     = 1'b0;
        o_hold_ex      = 1'b0;
        o_bubble_ex    = 1'b0;
        o_bubble_mem   = 1'b0;
        o_flush_if_id  = 1'b0;
        o_fwd_a        = FWD_RF;
        o_fwd_b        = FWD_RF;
        o_muldiv_start = 1'b0;
        o_muldiv_done  = 1'b0;
        o_muldiv_busy  = 1'b0;

        if (!i_rst) begin
            o_fwd_a = fwd_sel(i_ex_ra1, i_mem_reg_write_en, i_mem_is_load, i_mem_wa3,
                              i_wb_reg_write_en, i_wb_wa3);
            o_fwd_b = fwd_sel(i_ex_ra2, i_mem_reg_write_en, i_mem_is_load, i_mem_wa3,
                              i_wb_reg_write_en, i_wb_wa3);
            o_muldiv_busy = (r_state == BUSY);

            case (r_state)
                IDLE: begin
                    if (i_ex_valid && i_ex_is_muldiv) begin
                        o_muldiv_start = 1'b1;
                        w_held         = 1'b1;
                        w_cnt_nxt      = i_ex_is_div ? DIV_LOAD : MUL_LOAD;
                        w_state_nxt    = BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        w_held    = 1'b1;
                        w_cnt_nxt = r_cnt - CW'(1);
                    end else begin
                        // Last EX cycle: release so the result moves to MEM.
                        o_muldiv_done = 1'b1;
                        w_state_nxt   = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase

            if (w_held) begin
                o_hold_ex    = 1'b1;
                o_stall_if   = 1'b1;
                o_stall_id   = 1'b1;
                o_bubble_mem = 1'b1;
            end else if (i_ex_redirect) begin
                o_flush_if_id = 1'b1;
                o_bubble_ex   = 1'b1;
            end else if (w_lu) begin
                o_stall_if  = 1'b1;
                o_stall_id  = 1'b1;
                o_bubble_ex = 1'b1;
            end
        end
    end

    assign o_stall_cnt  = r_stall_cnt;
    assign o_flush_cnt  = r_flush_cnt;
    assign o_muldiv_cnt = r_muldiv_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic, all
// compared each cycle against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned DIV_LAT = 33;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CMOD    = 1 << CNT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0] id_ra1, id_ra2;
    logic       ex_valid, ex_is_load, ex_reg_write_en, ex_is_muldiv, ex_is_div;
    logic [4:0] ex_ra1, ex_ra2, ex_wa3;
    logic       ex_redirect;
    logic       mem_reg_write_en, mem_is_load;
    logic [4:0] mem_wa3;
    logic       wb_reg_write_en;
    logic [4:0] wb_wa3;

    logic       stall_if, stall_id, hold_ex, bubble_ex, bubble_mem, flush_if_id;
    logic [1:0] fwd_a, fwd_b;
    logic       muldiv_start, muldiv_done, muldiv_busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, muldiv_cnt;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
        .i_id_ra1(id_ra1), .i_id_ra2(id_ra2),
        .i_ex_valid(ex_valid), .i_ex_is_load(ex_is_load), .i_ex_reg_write_en(ex_reg_write_en),
        .i_ex_is_muldiv(ex_is_muldiv), .i_ex_is_div(ex_is_div),
        .i_ex_ra1(ex_ra1), .i_ex_ra2(ex_ra2), .i_ex_wa3(ex_wa3), .i_ex_redirect(ex_redirect),
        .i_mem_reg_write_en(mem_reg_write_en), .i_mem_is_load(mem_is_load), .i_mem_wa3(mem_wa3),
        .i_wb_reg_write_en(wb_reg_write_en), .i_wb_wa3(wb_wa3),
        .o_stall_if(stall_if), .o_stall_id(stall_id), .o_hold_ex(hold_ex),
        .o_bubble_ex(bubble_ex), .o_bubble_mem(bubble_mem), .o_flush_if_id(flush_if_id),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
        .o_muldiv_start(muldiv_start), .o_muldiv_done(muldiv_done), .o_muldiv_busy(muldiv_busy),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt), .o_muldiv_cnt(muldiv_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: an operation in flight is tracked by how many
    // cycles it has spent in EX and how long it must stay there.
    bit m_active  = 0;
    int m_elapsed = 0;
    int m_lat     = 0;
    int m_stall   = 0;
    int m_flush   = 0;
    int m_md      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] ra);
        if (mem_reg_write_en && !mem_is_load && mem_wa3 != 0 && mem_wa3 == ra) return 2'b01;
        if (wb_reg_write_en && wb_wa3 != 0 && wb_wa3 == ra) return 2'b10;
        return 2'b00;
    endfunction

    // Check the current cycle against the model, advance the model, then move
    // to just after the next falling edge where new inputs are applied.
    task automatic run_cycle();
        bit e_sif, e_sid, e_hold, e_bex, e_bmem, e_flush, e_start, e_done, e_busy;
        bit held, lu;
        logic [1:0] e_fa, e_fb;
        #1;
        {e_sif, e_sid, e_hold, e_bex, e_bmem, e_flush, e_start, e_done, e_busy} = '0;
        e_fa = 2'b00;
        e_fb = 2'b00;
        held = 0;
        if (!rst) begin
            e_fa   = ref_fwd(ex_ra1);
            e_fb   = ref_fwd(ex_ra2);
            e_busy = m_active;
            lu = ex_valid && ex_is_load && ex_reg_write_en && ex_wa3 != 0 && id_valid &&
                 ((id_uses_rs1 && id_ra1 == ex_wa3) || (id_uses_rs2 && id_ra2 == ex_wa3));
            if (m_active) begin
                if (m_elapsed + 1 == m_lat - 1) e_done = 1;
                else held = 1;
            end else if (ex_valid && ex_is_muldiv) begin
                e_start = 1;
                held    = 1;
            end
            if (held) begin
                e_hold = 1; e_sif = 1; e_sid = 1; e_bmem = 1;
            end else if (ex_redirect) begin
                e_flush = 1; e_bex = 1;
            end else if (lu) begin
                e_sif = 1; e_sid = 1; e_bex = 1;
            end
        end
        chk("ctrl", 32'({stall_if, stall_id, hold_ex, bubble_ex, bubble_mem, flush_if_id,
                         muldiv_start, muldiv_done, muldiv_busy}),
                    32'({e_sif, e_sid, e_hold, e_bex, e_bmem, e_flush, e_start, e_done, e_busy}));
        chk("fwd_a", 32'(fwd_a), 32'(e_fa));
        chk("fwd_b", 32'(fwd_b), 32'(e_fb));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        chk("muldiv_cnt", 32'(muldiv_cnt), 32'(m_md));
        if (rst) begin
            m_active = 0;
            m_stall  = 0;
            m_flush  = 0;
            m_md     = 0;
        end else begin
            if (e_start) begin
                m_active  = 1;
                m_elapsed = 0;
                m_lat     = ex_is_div ? int'(DIV_LAT) : int'(MUL_LAT);
            end else if (m_active) begin
                m_elapsed++;
                if (e_done) m_active = 0;
            end
            m_stall = (m_stall + int'(e_sid)) % CMOD;
            m_flush = (m_flush + int'(e_flush)) % CMOD;
            m_md    = (m_md + int'(e_start)) % CMOD;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rst = 0;
        {id_valid, id_uses_rs1, id_uses_rs2} = '0;
        id_ra1 = 0; id_ra2 = 0;
        {ex_valid, ex_is_load, ex_reg_write_en, ex_is_muldiv, ex_is_div, ex_redirect} = '0;
        ex_ra1 = 0; ex_ra2 = 0; ex_wa3 = 0;
        {mem_reg_write_en, mem_is_load, wb_reg_write_en} = '0;
        mem_wa3 = 0; wb_wa3 = 0;
    endtask

    task automatic set_load_use(input logic [4:0] wa, input logic [4:0] ra);
        ex_valid = 1; ex_is_load = 1; ex_reg_write_en = 1; ex_wa3 = wa;
        id_valid = 1; id_uses_rs1 = 1; id_ra1 = ra;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        @(negedge clk);
        run_cycle();
        run_cycle();
        rst = 0;
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);

        // Load-use: matching, non-matching, and x0 destination.
        set_load_use(5'd5, 5'd5);
        #1 chk("lu_stall_id", 32'(stall_id), 32'd1);
        run_cycle();
        set_load_use(5'd5, 5'd6);
        run_cycle();
        set_load_use(5'd0, 5'd0);
        #1 chk("lu_x0_stall", 32'(stall_id), 32'd0);
        run_cycle();
        clear_inputs();

        // Forwarding priority and x0 exclusion.
        mem_reg_write_en = 1; mem_wa3 = 7; wb_reg_write_en = 1; wb_wa3 = 7;
        ex_ra1 = 7; ex_ra2 = 0;
        #1 chk("fwd_mem", 32'(fwd_a), 32'd1);
        run_cycle();
        mem_is_load = 1;
        #1 chk("fwd_wb", 32'(fwd_a), 32'd2);
        run_cycle();
        clear_inputs();

        // Mul then div back to back, then idle.
        ex_valid = 1; ex_is_muldiv = 1;
        for (int i = 0; i < int'(MUL_LAT); i++) run_cycle();
        ex_is_div = 1;
        for (int i = 0; i < int'(DIV_LAT) - 1; i++) run_cycle();
        #1 chk("div_done", 32'(muldiv_done), 32'd1);
        run_cycle();
        clear_inputs();
        run_cycle();
        chk("muldiv_cnt_two", 32'(muldiv_cnt), 32'd2);

        // Redirect outranks load-use.
        set_load_use(5'd9, 5'd9);
        ex_redirect = 1;
        run_cycle();
        clear_inputs();
        run_cycle();

        // Reset five cycles into a divide.
        ex_valid = 1; ex_is_muldiv = 1; ex_is_div = 1;
        for (int i = 0; i < 5; i++) run_cycle();
        rst = 1;
        run_cycle();
        clear_inputs();
        #1 chk("abort_busy", 32'(muldiv_busy), 32'd0);
        chk("abort_mdcnt", 32'(muldiv_cnt), 32'd0);
        run_cycle();

        // Stall counter wraps at 2^CNT_W.
        set_load_use(5'd3, 5'd3);
        for (int i = 0; i < int'(CMOD); i++) run_cycle();
        chk("stall_wrap", 32'(stall_cnt), 32'd0);
        clear_inputs();

        // Random traffic with a small register range to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 99) == 0);
            id_valid         = 1'($urandom);
            id_uses_rs1      = 1'($urandom);
            id_uses_rs2      = 1'($urandom);
            id_ra1           = 5'($urandom_range(0, 7));
            id_ra2           = 5'($urandom_range(0, 7));
            ex_valid         = 1'($urandom);
            ex_is_load       = 1'($urandom);
            ex_reg_write_en  = 1'($urandom);
            ex_is_muldiv     = ($urandom_range(0, 11) == 0);
            ex_is_div        = ($urandom_range(0, 3) == 0);
            ex_ra1           = 5'($urandom_range(0, 7));
            ex_ra2           = 5'($urandom_range(0, 7));
            ex_wa3           = 5'($urandom_range(0, 7));
            ex_redirect      = ($urandom_range(0, 7) == 0);
            mem_reg_write_en = 1'($urandom);
            mem_is_load      = 1'($urandom);
            mem_wa3          = 5'($urandom_range(0, 7));
            wb_reg_write_en  = 1'($urandom);
            wb_wa3           = 5'($urandom_range(0, 7));
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
